// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter and sequencer for a shared two-source
// registered select path. Requester 1 feeds i1 and requester 2 feeds i2.
// The block grants the path to one requester at a time, drives the registered
// select, and owns the 2-bit output register. Each source has a fixed encoding:
// {i1,0} for source 1 and {1,i2} for source 2. Grants are capped at BURST
// cycles so neither requester can starve the other.
//
// Ports:
//   clk           rising-edge clock
//   clr           asynchronous clear, active-high
//   req1, req2    level requests, held high while the path is wanted
//   last1, last2  final-cycle marker, only meaningful while the matching grant is high
//   i1, i2        source data bits
//   gnt1, gnt2    registered grants, never both high
//   sel           registered select: 1 = source 1, 0 = source 2; holds while idle
//   busy          registered, high while a grant is active
//   o             registered 2-bit output word
module mux_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req1,
  input  logic       req2,
  input  logic       last1,
  input  logic       last2,
  input  logic       i1,
  input  logic       i2,
  output logic       gnt1,
  output logic       gnt2,
  output logic       sel,
  output logic       busy,
  output logic [1:0] o
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prio2_q, prio2_d;   // 1: requester 2 was served last
  logic          gnt1_q, gnt1_d;
  logic          gnt2_q, gnt2_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic [1:0]    o_q, o_d;
  logic          enter;              // a grant (new or restarted) begins next cycle

  // Next-state, counter, priority and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio2_d = prio2_q;
    o_d     = o_q;
    enter   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req1 && (!req2 || prio2_q)) begin
          state_d = G1;
          enter   = 1'b1;
        end else if (req2) begin
          state_d = G2;
          enter   = 1'b1;
        end
      end
      G1: begin
        o_d = {i1, 1'b0};
        if (last1 || !req1 || (cnt_q == CNT_MAX)) begin
          if (req2) begin
            state_d = G2;
            enter   = 1'b1;
          end else if (req1 && !last1) begin
            state_d = G1;          // burst-limit release, restart the grant
            enter   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      G2: begin
        o_d = {1'b1, i2};
        if (last2 || !req2 || (cnt_q == CNT_MAX)) begin
          if (req1) begin
            state_d = G1;
            enter   = 1'b1;
          end else if (req2 && !last2) begin
            state_d = G2;
            enter   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter) begin
      cnt_d   = '0;
      prio2_d = (state_d == G2);
    end else if ((state_q != IDLE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end

    gnt1_d = (state_d == G1);
    gnt2_d = (state_d == G2);
    busy_d = (state_d != IDLE);
    if (state_d == G1) begin
      sel_d = 1'b1;
    end else if (state_d == G2) begin
      sel_d = 1'b0;
    end else begin
      sel_d = sel_q;
    end
  end

  // State and output registers; clr forces every output low at once
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prio2_q <= 1'b1;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      o_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio2_q <= prio2_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      o_q     <= o_d;
    end
  end

  assign gnt1 = gnt1_q;
  assign gnt2 = gnt2_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign o    = o_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Testbench for mux_arbiter (BURST=4). It drives inputs on the falling edge,
// queues the expected outputs, and checks them 1 time unit after the rising edge.
module tb_mux_arbiter;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       clr, req1, req2, last1, last2, i1, i2;
  logic       gnt1, gnt2, sel, busy;
  logic [1:0] o;

  mux_arbiter #(.BURST(BURST)) dut (
    .clk(clk), .clr(clr), .req1(req1), .req2(req2), .last1(last1), .last2(last2),
    .i1(i1), .i2(i2), .gnt1(gnt1), .gnt2(gnt2), .sel(sel), .busy(busy), .o(o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic req1; logic req2; logic last1; logic last2; logic i1; logic i2;} stim_t;
  typedef struct packed {logic gnt1; logic gnt2; logic sel; logic busy; logic [1:0] o;} exp_t;
  typedef struct packed {stim_t s; exp_t e;} vec_t;

  vec_t tbl[28];
  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state: mlen counts granted cycles including the current one
  int    mst;
  int    mlen;
  logic  mprio2;
  exp_t  mexp;

  function automatic vec_t mk(input logic [5:0] s, input logic [3:0] g, input logic [1:0] oo);
    vec_t v;
    v.s = s;
    v.e = {g, oo};
    return v;
  endfunction

  function automatic void model_rst();
    mst    = 0;
    mlen   = 0;
    mprio2 = 1'b1;
    mexp   = '0;
  endfunction

  function automatic void model_edge(input stim_t s);
    int   nst;
    logic entry;
    nst   = mst;
    entry = 1'b0;
    if (mst == 1) mexp.o = {s.i1, 1'b0};
    else if (mst == 2) mexp.o = {1'b1, s.i2};
    case (mst)
      0: begin
        if (s.req1 && s.req2) begin nst = mprio2 ? 1 : 2; entry = 1'b1; end
        else if (s.req1) begin nst = 1; entry = 1'b1; end
        else if (s.req2) begin nst = 2; entry = 1'b1; end
      end
      1: begin
        if (s.last1 || !s.req1 || mlen == BURST) begin
          if (s.req2) begin nst = 2; entry = 1'b1; end
          else if (s.req1 && !s.last1) entry = 1'b1;
          else nst = 0;
        end else mlen++;
      end
      default: begin
        if (s.last2 || !s.req2 || mlen == BURST) begin
          if (s.req1) begin nst = 1; entry = 1'b1; end
          else if (s.req2 && !s.last2) entry = 1'b1;
          else nst = 0;
        end else mlen++;
      end
    endcase
    if (entry) begin
      mlen   = 1;
      mprio2 = (nst == 2);
    end
    mst       = nst;
    mexp.gnt1 = (nst == 1);
    mexp.gnt2 = (nst == 2);
    mexp.busy = (nst != 0);
    if (nst == 1) mexp.sel = 1'b1;
    else if (nst == 2) mexp.sel = 1'b0;
  endfunction

  task automatic check_out(input string nm);
    exp_t a, e;
    a = {gnt1, gnt2, sel, busy, o};
    checks++;
    if (sbq.size() == 0) begin
      $display("FAIL %s: no expected entry queued, got %b", nm, a);
      return;
    end
    e = sbq.pop_front();
    if (a === e) passes++;
    else $display("FAIL %s: gnt1 gnt2 sel busy o got %b %b %b %b %b, expected %b %b %b %b %b",
                  nm, a.gnt1, a.gnt2, a.sel, a.busy, a.o, e.gnt1, e.gnt2, e.sel, e.busy, e.o);
  endtask

  task automatic drive(input stim_t s, input logic c);
    clr = c;
    {req1, req2, last1, last2, i1, i2} = s;
  endtask

  task automatic apply(input stim_t s, input logic c, input exp_t e, input string nm);
    @(negedge clk);
    drive(s, c);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  // Both grants high at once is never legal, not even across clr
  always @(gnt1 or gnt2) begin
    if (gnt1 && gnt2) begin
      checks++;
      $display("FAIL mutex: gnt1=%b gnt2=%b at %0t", gnt1, gnt2, $time);
    end
  end

  initial begin
    // stim order: req1 req2 last1 last2 i1 i2 | expected gnt1 gnt2 sel busy, o
    tbl[0]  = mk(6'b110000, 4'b1011, 2'b00);  // first tie after reset -> requester 1
    tbl[1]  = mk(6'b000000, 4'b0010, 2'b00);
    tbl[2]  = mk(6'b100010, 4'b1011, 2'b00);  // single requester, 3-cycle grant
    tbl[3]  = mk(6'b100010, 4'b1011, 2'b10);
    tbl[4]  = mk(6'b100010, 4'b1011, 2'b10);
    tbl[5]  = mk(6'b101010, 4'b0010, 2'b10);
    tbl[6]  = mk(6'b000000, 4'b0010, 2'b10);
    tbl[7]  = mk(6'b110000, 4'b0101, 2'b10);  // contention: G2 for 4 cycles
    tbl[8]  = mk(6'b110000, 4'b0101, 2'b10);
    tbl[9]  = mk(6'b110000, 4'b0101, 2'b10);
    tbl[10] = mk(6'b110000, 4'b0101, 2'b10);
    tbl[11] = mk(6'b110000, 4'b1011, 2'b10);  // burst limit -> handover, no gap
    tbl[12] = mk(6'b110000, 4'b1011, 2'b00);
    tbl[13] = mk(6'b110000, 4'b1011, 2'b00);
    tbl[14] = mk(6'b011000, 4'b0101, 2'b00);  // last1 and req1 drop together
    tbl[15] = mk(6'b010101, 4'b0000, 2'b11);  // last2 on first granted cycle
    tbl[16] = mk(6'b000000, 4'b0000, 2'b11);
    tbl[17] = mk(6'b010000, 4'b0101, 2'b11);  // req2 only, re-grant across bursts
    for (int i = 18; i < 27; i++) tbl[i] = mk(6'b010000, 4'b0101, 2'b10);
    tbl[27] = mk(6'b000000, 4'b0000, 2'b10);

    drive('0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    sbq.push_back('0);
    check_out("reset");
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 28; i++) apply(tbl[i].s, 1'b0, tbl[i].e, $sformatf("vec%0d", i));

    // clr mid-G2: outputs drop without a clock edge
    apply(6'b010001, 1'b0, {4'b0101, 2'b10}, "clr_g2_enter");
    apply(6'b010001, 1'b0, {4'b0101, 2'b11}, "clr_g2_run");
    #2;
    drive('0, 1'b1);
    #1;
    sbq.push_back('0);
    check_out("clr_async_g2");
    apply(6'b110000, 1'b0, {4'b1011, 2'b00}, "tie_after_clr_g2");
    apply(6'b100000, 1'b0, {4'b1011, 2'b00}, "clr_g1_run");
    // clr mid-G1: priority must return to its reset value
    #2;
    drive('0, 1'b1);
    #1;
    sbq.push_back('0);
    check_out("clr_async_g1");
    apply(6'b110000, 1'b0, {4'b1011, 2'b00}, "tie_after_clr_g1");
    apply(6'b000000, 1'b0, {4'b0010, 2'b00}, "idle_after_tie");

    // Random traffic against the reference model
    for (int k = 0; k < 10000; k++) begin
      stim_t      s;
      logic       c, pg;
      logic [1:0] po;
      @(negedge clk);
      s.req1  = ($urandom_range(0, 3) != 0);
      s.req2  = ($urandom_range(0, 3) != 0);
      s.last1 = ($urandom_range(0, 4) == 0);
      s.last2 = ($urandom_range(0, 4) == 0);
      s.i1    = 1'($urandom);
      s.i2    = 1'($urandom);
      c = (k == 0) || ($urandom_range(0, 199) == 0);
      drive(s, c);
      if (c) model_rst();
      else model_edge(s);
      sbq.push_back(mexp);
      pg = gnt1 | gnt2;
      po = o;
      @(posedge clk);
      #1;
      check_out("random");
      if (!pg && !c) begin
        checks++;
        if (o === po) passes++;
        else $display("FAIL o_hold: o changed to %b from %b with no grant at %0t", o, po, $time);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
